// File: rtl/wisc_mem_pkg.sv
// Shared types and default sizes for the WISC-S15 memory-stage access controller.
package wisc_mem_pkg;

    localparam int unsigned DefDataW   = 16;
    localparam int unsigned DefAddrW   = 16;
    localparam int unsigned DefRdW     = 4;
    localparam int unsigned DefTimeout = 16;

    typedef enum logic [1:0] {
        StIdle,
        StBusy,
        StDone
    } mem_state_e;

endpackage

// File: rtl/mem_timeout_cnt.sv
// Watchdog counter for an outstanding data-memory access; flags expiry at TIMEOUT-1.
module mem_timeout_cnt #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int unsigned CntW = $clog2(TIMEOUT);
    localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);

    logic [CntW-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (clear) begin
            cnt_q <= '0;
        end else if (enable && !expired) begin
            cnt_q <= cnt_q + CntW'(1);
        end
    end

    assign expired = (cnt_q == CntLast);

endmodule

// File: rtl/mem_access_ctrl.sv
// Memory-stage access controller: drives a req/ack data memory and stalls the pipeline
// until each load/store completes or the watchdog abandons it.
module mem_access_ctrl
    import wisc_mem_pkg::*;
#(
    parameter int unsigned DATA_W  = DefDataW,
    parameter int unsigned ADDR_W  = DefAddrW,
    parameter int unsigned RD_W    = DefRdW,
    parameter int unsigned TIMEOUT = DefTimeout
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ex_mem_read,
    input  logic              ex_mem_write,
    input  logic [ADDR_W-1:0] ex_addr,
    input  logic [DATA_W-1:0] ex_wdata,
    input  logic [RD_W-1:0]   ex_reg_rd,
    input  logic [DATA_W-1:0] ex_alu_result,
    output logic              mem_stall,
    output logic              dm_req,
    output logic              dm_we,
    output logic [ADDR_W-1:0] dm_addr,
    output logic [DATA_W-1:0] dm_wdata,
    input  logic              dm_ack,
    input  logic [DATA_W-1:0] dm_rdata,
    output logic [DATA_W-1:0] mem_read_data,
    output logic [RD_W-1:0]   reg_rd,
    output logic [DATA_W-1:0] alu_result,
    output logic              mem_err
);

    mem_state_e state_q, state_d;

    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] rdata_q;
    logic              err_q;

    logic req_valid;
    logic req_illegal;
    logic expired;
    logic cnt_clear;
    logic cnt_en;

    assign req_valid   = ex_mem_read ^ ex_mem_write;
    assign req_illegal = ex_mem_read & ex_mem_write;

    always_comb begin
        state_d   = state_q;
        cnt_clear = 1'b0;
        cnt_en    = 1'b0;
        mem_stall = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (req_valid) begin
                    state_d   = StBusy;
                    cnt_clear = 1'b1;
                    mem_stall = 1'b1;
                end
            end
            StBusy: begin
                mem_stall = 1'b1;
                if (dm_ack || expired) begin
                    state_d = StDone;
                end else begin
                    cnt_en = 1'b1;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
        // Request inputs may be live during reset; never stall the pipeline then.
        if (!rst_n) begin
            mem_stall = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            if (state_q == StIdle && req_valid) begin
                we_q    <= ex_mem_write;
                addr_q  <= ex_addr;
                wdata_q <= ex_wdata;
            end
            if (state_q == StBusy) begin
                if (dm_ack) begin
                    if (!we_q) begin
                        rdata_q <= dm_rdata;
                    end
                end else if (expired) begin
                    rdata_q <= '0;
                end
            end
            err_q <= (state_q == StIdle && req_illegal) ||
                     (state_q == StBusy && !dm_ack && expired);
        end
    end

    mem_timeout_cnt #(
        .TIMEOUT(TIMEOUT)
    ) u_timeout_cnt (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (cnt_clear),
        .enable (cnt_en),
        .expired(expired)
    );

    // dm_req decodes straight from the state register so reset drops it without a clock.
    assign dm_req        = (state_q == StBusy);
    assign dm_we         = we_q;
    assign dm_addr       = addr_q;
    assign dm_wdata      = wdata_q;
    assign mem_read_data = rdata_q;
    assign mem_err       = err_q;
    assign reg_rd        = ex_reg_rd;
    assign alu_result    = ex_alu_result;

endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
- Memory-stage access controller for the WISC-S15 pipeline; it produces the memory read data that the MEM/WB register consumes.
- Accepts load/store requests from the EX/MEM register and drives a variable-latency data memory over a req/ack handshake.
- Stalls the pipeline until each access completes, then presents read data, destination register and ALU result to the MEM/WB register inputs.
- Includes a watchdog timeout so a lost acknowledge cannot hang the pipeline.

Parameters:
DATA_W, 16, data word width
ADDR_W, 16, data memory address width
RD_W, 4, register-file index width
TIMEOUT, 16, number of BUSY cycles without dm_ack before the access is abandoned (must be >= 2)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  reset, asynchronous, active-low
ex_mem_read  input  1  load request from EX/MEM
ex_mem_write  input  1  store request from EX/MEM
ex_addr  input  ADDR_W  effective address
ex_wdata  input  DATA_W  store data
ex_reg_rd  input  RD_W  destination register
ex_alu_result  input  DATA_W  ALU result
mem_stall  output  1  holds PC, IF/ID, ID/EX, EX/MEM and MEM/WB when 1
dm_req  output  1  memory request
dm_we  output  1  1 = write, 0 = read
dm_addr  output  ADDR_W  memory address
dm_wdata  output  DATA_W  memory write data
dm_ack  input  1  memory completion; valid only while dm_req = 1
dm_rdata  input  DATA_W  memory read data; valid with dm_ack on reads
mem_read_data  output  DATA_W  to MEM/WB mem_read_data_in
reg_rd  output  RD_W  to MEM/WB reg_rd_in
alu_result  output  DATA_W  to MEM/WB alu_result_in
mem_err  output  1  one-cycle error pulse

Behaviour:
- Interface decision: one clock; reset is asynchronous and active-low. Ports are named clk and rst_n.
- Reset values: state IDLE, dm_req 0, dm_we 0, dm_addr 0, dm_wdata 0, mem_read_data 0, mem_err 0, timeout count 0. mem_stall is forced to 0 while rst_n = 0.
- reg_rd and alu_result are combinational pass-throughs of ex_reg_rd and ex_alu_result. EX/MEM is stalled, so both stay stable for the whole access.
- FSM states:
  - IDLE: exactly one of read/write is high -> latch addr, wdata and we, clear the count, go to BUSY. mem_stall = 1 combinationally in this cycle.
  - IDLE: neither request -> stay in IDLE, stall 0.
  - BUSY: dm_req = 1 with addr/we/wdata held stable; mem_stall = 1.
    - dm_ack = 1 -> on a read, capture dm_rdata into mem_read_data; go to DONE.
    - No ack and count == TIMEOUT-1 -> mem_read_data <= 0, mem_err pulse in the DONE cycle, go to DONE.
    - Otherwise increment the count.
  - DONE: dm_req = 0, mem_stall = 0. The pipeline advances at this edge. Next state is IDLE unconditionally; a new request is evaluated in IDLE.
- Latency: op presented in cycle 0 -> dm_req high from cycle 1 -> ack in cycle k (k >= 1) -> DONE in cycle k+1.
- Minimum stall is 2 cycles; each memory op occupies k+2 cycles.
- Stores leave mem_read_data unchanged.
- Both ex_mem_read and ex_mem_write high: illegal.
  - No memory access is made and there is no stall.
  - mem_err pulses in the next cycle.
  - State stays IDLE.
- dm_ack while dm_req = 0 (late ack after a timeout, or in IDLE/DONE) is ignored.
- rst_n asserted mid-access: the access is abandoned immediately and dm_req drops asynchronously. The memory is required to discard the request.
- mem_err is registered, high for exactly one cycle per error event.

Decomposition:
- Shared package wisc_mem_pkg holds:
  - the state enum (IDLE, BUSY, DONE)
  - default DATA_W / ADDR_W / RD_W constants
  - the TIMEOUT default
- One natural sub-module: mem_timeout_cnt.
  - Inputs: clear, enable.
  - Output: expired flag at TIMEOUT-1.
  - Count width: $clog2(TIMEOUT).
- The FSM and datapath latches stay in mem_access_ctrl.

Test Plan:
- Read, ack latency 3:
  - Stimulus: ex_mem_read = 1, ex_addr = 0x0040; dm_ack in the 3rd cycle of dm_req with dm_rdata = 0xBEEF.
  - Response: mem_stall high for 4 cycles, mem_read_data = 0xBEEF in the DONE cycle, reg_rd/alu_result unchanged throughout.
- Write, immediate ack:
  - Stimulus: ex_mem_write = 1, addr 0x0010, wdata 0x1234; ack in the first dm_req cycle.
  - Response: dm_we = 1, dm_addr/dm_wdata stable, stall exactly 2 cycles, mem_read_data unchanged.
- Timeout:
  - Stimulus: TIMEOUT = 4, read with no ack, then ack asserted 2 cycles after DONE.
  - Response: dm_req high for 4 cycles, mem_err pulses once, mem_read_data = 0x0000, late ack ignored, state IDLE.
- Illegal request:
  - Stimulus: ex_mem_read = ex_mem_write = 1.
  - Response: dm_req stays 0, mem_stall 0, mem_err high for one cycle.
- Reset mid-access:
  - Stimulus: rst_n low in the 2nd BUSY cycle.
  - Response: dm_req, mem_stall and mem_err go 0 without waiting for a clock edge; after release, state IDLE and mem_read_data = 0.
- Back-to-back loads:
  - Stimulus: two consecutive reads, addrs 0x0002 and 0x0004, each acked after 1 cycle.
  - Response: one IDLE cycle (stall 1) between the DONE of the first and dm_req of the second; data values appear in their respective DONE cycles.
